// File: rtl/conflict_cam.sv
// Small content-addressable table of keys with associated hashes.
// Single-cycle lookup, FIFO-order insertion, duplicate keys update in place.
module conflict_cam #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned HASH_WIDTH = 12,
    parameter int unsigned WRAP       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [HASH_WIDTH-1:0]         wr_hash,
    input  logic                          lk_valid,
    input  logic [DATA_WIDTH-1:0]         lk_data,
    output logic                          rsp_valid,
    output logic                          rsp_hit,
    output logic [HASH_WIDTH-1:0]         rsp_hash,
    output logic [$clog2(DEPTH)-1:0]      rsp_index,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          full,
    output logic                          drop_err
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;

    logic [DEPTH-1:0]      r_valid;
    logic [DATA_WIDTH-1:0] r_key  [DEPTH];
    logic [HASH_WIDTH-1:0] r_hash [DEPTH];
    logic [IW-1:0]         r_wptr;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_drop;
    logic                  r_rsp_valid;
    logic                  r_rsp_hit;
    logic [HASH_WIDTH-1:0] r_rsp_hash;
    logic [IW-1:0]         r_rsp_index;

    logic                  w_lk_hit;
    logic [IW-1:0]         w_lk_idx;
    logic                  w_wr_hit;
    logic [IW-1:0]         w_wr_idx;
    logic                  w_wr_ready;
    logic                  w_wr_new;
    logic                  w_wr_upd;
    logic                  w_lk_ok;
    logic [CW-1:0]         w_count_nxt;

    // Lowest-index match wins: scan downwards so the last assignment is the smallest index.
    always_comb begin
        w_lk_hit = 1'b0;
        w_lk_idx = '0;
        w_wr_hit = 1'b0;
        w_wr_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_key[i] == lk_data)) begin
                w_lk_hit = 1'b1;
                w_lk_idx = IW'(i);
            end
            if (r_valid[i] && (r_key[i] == wr_data)) begin
                w_wr_hit = 1'b1;
                w_wr_idx = IW'(i);
            end
        end
    end

    assign w_wr_ready  = !r_full || (WRAP != 0) || w_wr_hit;
    assign w_wr_new    = wr_valid && w_wr_ready && !clear && !w_wr_hit;
    assign w_wr_upd    = wr_valid && w_wr_ready && !clear && w_wr_hit;
    assign w_lk_ok     = w_lk_hit && !clear;
    assign w_count_nxt = r_full ? r_count : r_count + CW'(1);

    // Control state and lookup response; rst dominates everything, then clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_wptr      <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_drop      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_hash  <= '0;
            r_rsp_index <= '0;
        end else begin
            r_rsp_valid <= lk_valid;
            if (lk_valid) begin
                r_rsp_hit   <= w_lk_ok;
                r_rsp_hash  <= w_lk_ok ? r_hash[w_lk_idx] : '0;
                r_rsp_index <= w_lk_ok ? w_lk_idx : '0;
            end
            if (clear) begin
                r_valid <= '0;
                r_wptr  <= '0;
                r_count <= '0;
                r_full  <= 1'b0;
                r_drop  <= 1'b0;
            end else begin
                if (w_wr_new) begin
                    r_valid[r_wptr] <= 1'b1;
                    r_wptr          <= r_wptr + IW'(1);
                    r_count         <= w_count_nxt;
                    r_full          <= (w_count_nxt == CW'(DEPTH));
                end
                if (wr_valid && !w_wr_ready) begin
                    r_drop <= 1'b1;
                end
            end
        end
    end

    // Key/hash storage carries no reset; the valid bits gate its use.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_wr_new) begin
                r_key[r_wptr]  <= wr_data;
                r_hash[r_wptr] <= wr_hash;
            end else if (w_wr_upd) begin
                r_hash[w_wr_idx] <= wr_hash;
            end
        end
    end

    assign wr_ready  = w_wr_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_hash  = r_rsp_hash;
    assign rsp_index = r_rsp_index;
    assign count     = r_count;
    assign full      = r_full;
    assign drop_err  = r_drop;

endmodule
